// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state encoding and widths for the memory responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam int WCNT_W = 4;
  localparam int DATA_W = 8;
endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram: DEPTH x 8 byte RAM, synchronous write, combinational read
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int AW = 8,
  parameter int DEPTH = 256,
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     adr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DATA_W-1:0] mem [DEPTH];
  assign rdata = mem[adr[IW-1:0]];
  always_ff @(posedge clk)
    if (we) mem[adr[IW-1:0]] <= wdata;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: wait-stated byte memory responder for the multicycle controller; MEM_RESP_ERR_EN adds mem_err
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int AW = 8,
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_STATES = 2,
  parameter INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [AW-1:0]     adr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] memdata,
  output logic              mem_ready
`ifdef MEM_RESP_ERR_EN
  ,
  output logic              mem_err
`endif
);
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("WAIT_STATES must be 0..15");
  end
  if (MEM_DEPTH < 1 || MEM_DEPTH > 2**AW) begin : g_bad_depth
    $error("MEM_DEPTH must be 1..2**AW");
  end
  localparam logic [WCNT_W-1:0] WS_M1 = WCNT_W'(WAIT_STATES - 1);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(MEM_DEPTH);
  state_t state, nxt;
  logic [WCNT_W-1:0] cnt;
  logic [AW-1:0] adr_q, ra;
  logic [DATA_W-1:0] wd_q, rd;
  logic wr_q, req, wr_now, rng, we;
`ifdef MEM_RESP_ERR_EN
  logic both_q;
`endif
  assign req = memread | memwrite;
  // With zero wait states the read happens in the capture cycle, so look at the live address in IDLE
  assign ra = state == IDLE ? adr : adr_q;
  assign wr_now = state == IDLE ? memwrite : wr_q;
  assign rng = {1'b0, ra} < DEPTH_V;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE ? (req ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE) :
          state == WAIT ? (cnt == '0 ? RESP : WAIT) : IDLE;
  always_comb begin
    mem_ready = state == RESP && !reset;
    we = mem_ready && wr_q && rng;
`ifdef MEM_RESP_ERR_EN
    mem_err = mem_ready && (both_q || !rng);
`endif
  end
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      memdata <= '0;
      adr_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      both_q <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req) begin
        adr_q <= adr;
        wd_q <= writedata;
        wr_q <= memwrite;
        cnt <= WS_M1;
`ifdef MEM_RESP_ERR_EN
        both_q <= memread & memwrite;
`endif
      end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (nxt == RESP && !wr_now) memdata <= rng ? rd : '0;
    end
  mem_resp_ram #(.AW(AW), .DEPTH(MEM_DEPTH), .INIT_FILE(INIT_FILE)) u_ram (
    .clk  (clk),
    .we   (we),
    .adr  (ra),
    .wdata(wd_q),
    .rdata(rd)
  );
endmodule
